// File: rtl/apb_reg_slave_pkg.sv
// rtl/apb_reg_slave_pkg.sv - shared FSM encoding and address-error decode for the APB register slave
package apb_reg_slave_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_e;

   localparam int unsigned WAITCNT_W = 4;

   // Word index out of range or a non word-aligned byte offset.
   function automatic logic addr_err(input logic [31:0] word_idx,
                                     input logic [1:0]  byte_off,
                                     input logic [31:0] num_regs);
      return (word_idx >= num_regs) || (byte_off != 2'b00);
   endfunction

endpackage

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - word register array with byte-strobe write and combinational read
module apb_regfile #(
   parameter int DATAWIDTH = 32,
   parameter int NUMREGS   = 16,
   parameter int IDXW      = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   we_i,
   input  logic [IDXW-1:0]        idx_i,
   input  logic [DATAWIDTH-1:0]   wdata_i,
   input  logic [DATAWIDTH/8-1:0] wstrb_i,
   output logic [DATAWIDTH-1:0]   rdata_o
);

   localparam int NBYTES = DATAWIDTH / 8;

   logic [DATAWIDTH-1:0] regs_q [NUMREGS];
   logic                 idx_ok;

   // Guards non power-of-two register counts where idx_i can exceed the array.
   assign idx_ok = (32'(idx_i) < 32'(NUMREGS));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUMREGS; r++) begin
            regs_q[r] <= '0;
         end
      end else if (we_i && idx_ok) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (wstrb_i[b]) begin
               regs_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = idx_ok ? regs_q[idx_i] : '0;

endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB register slave: protocol FSM, wait-state counter, error and read-data logic
module apb_reg_slave
   import apb_reg_slave_pkg::*;
#(
   parameter int DATAWIDTH  = 32,
   parameter int ADDRWIDTH  = 8,
   parameter int NUMREGS    = 16,
   parameter int WAITSTATES = 1
) (
   input  logic                   PCLK,
   input  logic                   PRESET,
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic                   PWRITE,
   input  logic [ADDRWIDTH-1:0]   PADDR,
   input  logic [DATAWIDTH-1:0]   PWDATA,
   input  logic [DATAWIDTH/8-1:0] PSTRB,
   output logic [DATAWIDTH-1:0]   PRDATA,
   output logic                   PREADY,
   output logic                   PSLVERR,
   output logic                   prot_err
);

   localparam int                   IDXW       = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
   localparam logic [WAITCNT_W-1:0] WAIT_LIMIT = WAITCNT_W'(WAITSTATES);

   apb_state_e           state_q, state_d;
   logic [WAITCNT_W-1:0] waitcnt_q, waitcnt_d;
   logic                 prot_err_q, prot_err_d;
   logic                 bad_addr;
   logic                 xfer_done;
   logic                 wr_commit;
   logic [IDXW-1:0]      reg_idx;
   logic [DATAWIDTH-1:0] reg_rdata;

   assign bad_addr  = addr_err(32'(PADDR[ADDRWIDTH-1:2]), PADDR[1:0], 32'(NUMREGS));
   assign reg_idx   = PADDR[2 +: IDXW];
   assign xfer_done = !PRESET && (state_q == ACCESS) && PSEL && PENABLE && (waitcnt_q == WAIT_LIMIT);
   assign wr_commit = xfer_done && PWRITE && !bad_addr;

   assign PREADY   = xfer_done;
   assign PSLVERR  = xfer_done && bad_addr;
   assign PRDATA   = (xfer_done && !PWRITE && !bad_addr) ? reg_rdata : '0;
   assign prot_err = prot_err_q;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q    <= IDLE;
         waitcnt_q  <= '0;
         prot_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         waitcnt_q  <= waitcnt_d;
         prot_err_q <= prot_err_d;
      end
   end

   // After a completion the FSM assumes a back-to-back SETUP; a deselected bus there returns to IDLE.
   always_comb begin
      state_d    = state_q;
      waitcnt_d  = '0;
      prot_err_d = prot_err_q;
      case (state_q)
         IDLE: begin
            if (PENABLE) begin
               prot_err_d = 1'b1;
            end else if (PSEL) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (PENABLE) begin
               prot_err_d = 1'b1;
            end
            state_d = PSEL ? ACCESS : IDLE;
         end
         ACCESS: begin
            if (!PSEL) begin
               prot_err_d = 1'b1;
               state_d    = IDLE;
            end else if (xfer_done) begin
               state_d = SETUP;
            end else if (waitcnt_q != WAIT_LIMIT) begin
               waitcnt_d = waitcnt_q + 1'b1;
            end else begin
               waitcnt_d = waitcnt_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   apb_regfile #(
      .DATAWIDTH(DATAWIDTH),
      .NUMREGS  (NUMREGS),
      .IDXW     (IDXW)
   ) u_regfile (
      .clk_i  (PCLK),
      .rst_i  (PRESET),
      .we_i   (wr_commit),
      .idx_i  (reg_idx),
      .wdata_i(PWDATA),
      .wstrb_i(PSTRB),
      .rdata_o(reg_rdata)
   );

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - directed self-checking bench for apb_reg_slave (WAITSTATES=1 and WAITSTATES=0 instances)
module tb_apb_reg_slave;

   logic        PCLK   = 1'b0;
   logic        PRESET = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, use0 = 1'b0;
   logic [7:0]  paddr  = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb  = '0;

   logic [31:0] prdata1, prdata0;
   logic        pready1, pready0, pslverr1, pslverr0, perr1, perr0;

   int total = 0;
   int bad   = 0;

   always #5 PCLK = ~PCLK;

   apb_reg_slave #(.DATAWIDTH(32), .ADDRWIDTH(8), .NUMREGS(16), .WAITSTATES(1)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel & ~use0), .PENABLE(penable & ~use0),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1), .prot_err(perr1)
   );

   apb_reg_slave #(.DATAWIDTH(32), .ADDRWIDTH(8), .NUMREGS(16), .WAITSTATES(0)) dut0 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel & use0), .PENABLE(penable & use0),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .prot_err(perr0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One transfer; from_idle adds the IDLE-state select cycle, hold keeps PSEL high for a back-to-back follow-on.
   task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input bit from_idle, input bit hold,
                       output int nacc, output logic [31:0] rd, output logic err);
      bit done = 0;
      nacc = 0;
      rd   = 'x;
      err  = 1'bx;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      if (from_idle) begin
         @(posedge PCLK); #1;
      end
      @(posedge PCLK); #1;
      penable = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge PCLK);
         nacc++;
         if (use0 ? pready0 : pready1) begin
            done = 1;
            rd   = use0 ? prdata0 : prdata1;
            err  = use0 ? pslverr0 : pslverr1;
         end
         @(posedge PCLK); #1;
      end
      check("pready_timeout", 32'(done), 32'd1);
      penable = 1'b0;
      if (!hold) begin
         psel = 1'b0;
         @(posedge PCLK); #1;
      end
   endtask

   task automatic do_reset();
      PRESET = 1'b1;
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1'b0;
   endtask

   int          nacc;
   logic [31:0] rd;
   logic        er;

   initial begin
      repeat (3) @(posedge PCLK);
      #1 PRESET = 1'b0;
      @(negedge PCLK);
      check("rst_pready",   32'(pready1),  32'd0);
      check("rst_pslverr",  32'(pslverr1), 32'd0);
      check("rst_prdata",   prdata1,       32'd0);
      check("rst_prot_err", 32'(perr1),    32'd0);

      // Scenario 1
      xfer(1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 1, 0, nacc, rd, er);
      check("s1_wr_nacc", 32'(nacc), 32'd2);
      check("s1_wr_err",  32'(er),   32'd0);
      xfer(1'b0, 8'h08, 32'h0, 4'h0, 1, 0, nacc, rd, er);
      check("s1_rd_nacc", 32'(nacc), 32'd2);
      check("s1_rd_data", rd,        32'hDEADBEEF);
      check("s1_rd_err",  32'(er),   32'd0);
      @(negedge PCLK);
      check("idle_prdata", prdata1, 32'd0);

      // Scenario 2
      xfer(1'b1, 8'h04, 32'h11223344, 4'hF,    1, 0, nacc, rd, er);
      xfer(1'b1, 8'h04, 32'hAABBCCDD, 4'b0101, 1, 0, nacc, rd, er);
      xfer(1'b0, 8'h04, 32'h0,        4'h0,    1, 0, nacc, rd, er);
      check("s2_strb_data", rd, 32'h11BB33DD);

      // Scenario 3
      xfer(1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 1, 0, nacc, rd, er);
      check("s3_wr_slverr", 32'(er), 32'd1);
      xfer(1'b0, 8'h02, 32'h0, 4'h0, 1, 0, nacc, rd, er);
      check("s3_rd_slverr", 32'(er), 32'd1);
      check("s3_rd_data",   rd,      32'd0);
      xfer(1'b0, 8'h00, 32'h0, 4'h0, 1, 0, nacc, rd, er);
      check("s3_reg0_kept", rd, 32'd0);
      xfer(1'b0, 8'h08, 32'h0, 4'h0, 1, 0, nacc, rd, er);
      check("s3_reg8_kept", rd, 32'hDEADBEEF);

      // PSEL dropped during a wait state: no commit, sticky protocol error
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h12345678; pstrb = 4'hF;
      repeat (2) begin @(posedge PCLK); #1; end
      penable = 1'b1;
      @(negedge PCLK);
      check("abort_wait_pready", 32'(pready1), 32'd0);
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge PCLK); #1;
      check("abort_prot_err", 32'(perr1), 32'd1);
      xfer(1'b0, 8'h10, 32'h0, 4'h0, 1, 0, nacc, rd, er);
      check("abort_no_commit", rd, 32'd0);
      check("prot_err_sticky", 32'(perr1), 32'd1);

      do_reset();
      @(negedge PCLK);
      check("reset_clears_prot_err", 32'(perr1), 32'd0);

      // Scenario 4 on the zero-wait-state instance, PSEL held across transfers
      use0 = 1'b1;
      xfer(1'b1, 8'h00, 32'h00001111, 4'hF, 1, 1, nacc, rd, er);
      check("s4_wr0_cycles", 32'(1 + nacc), 32'd2);
      xfer(1'b1, 8'h04, 32'h22220000, 4'hF, 0, 1, nacc, rd, er);
      check("s4_wr4_cycles", 32'(1 + nacc), 32'd2);
      xfer(1'b0, 8'h00, 32'h0, 4'h0, 0, 1, nacc, rd, er);
      check("s4_rd0_cycles", 32'(1 + nacc), 32'd2);
      check("s4_rd0_data",   rd,            32'h00001111);
      xfer(1'b0, 8'h04, 32'h0, 4'h0, 0, 0, nacc, rd, er);
      check("s4_rd4_data",   rd,            32'h22220000);
      check("s4_prot_err",   32'(perr0),    32'd0);
      use0 = 1'b0;

      // Scenario 5
      psel = 1'b1; penable = 1'b1;
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge PCLK);
      check("s5_prot_err_set", 32'(perr1), 32'd1);
      xfer(1'b1, 8'h0C, 32'hCAFEF00D, 4'hF, 1, 0, nacc, rd, er);
      xfer(1'b0, 8'h0C, 32'h0, 4'h0, 1, 0, nacc, rd, er);
      check("s5_rd_data",       rd,          32'hCAFEF00D);
      check("s5_prot_err_held", 32'(perr1),  32'd1);

      // Scenario 6: reset lands in the wait state of a write to 0x0C
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h0BADF00D; pstrb = 4'hF;
      repeat (2) begin @(posedge PCLK); #1; end
      penable = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b1;
      @(negedge PCLK);
      check("s6_pready_in_reset", 32'(pready1), 32'd0);
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      @(negedge PCLK);
      check("s6_prot_err_cleared", 32'(perr1), 32'd0);
      xfer(1'b0, 8'h0C, 32'h0, 4'h0, 1, 0, nacc, rd, er);
      check("s6_reg_c_zero", rd, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, meaning PWDATA/PRDATA width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDRWIDTH, default 8, meaning PADDR width in bits.
REQ-003 SHALL have parameter NUMREGS, default 16, meaning number of word registers, at byte offsets 0,4,8,...
REQ-004 SHALL have parameter WAITSTATES, default 1, meaning ACCESS cycles with PREADY low before completion (0 to 15).
REQ-005 SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-006 PCLK  input  1  clock; all state changes on its rising edge.
REQ-007 PRESET  input  1  reset, synchronous, active-high.
REQ-008 PSEL  input  1  slave select from the address decoder.
REQ-009 PENABLE  input  1  ACCESS phase indicator.
REQ-010 PWRITE  input  1  1 = write, 0 = read.
REQ-011 PADDR  input  ADDRWIDTH  byte address.
REQ-012 PWDATA  input  DATAWIDTH  write data.
REQ-013 PSTRB  input  DATAWIDTH/8  write byte strobes.
REQ-014 PRDATA  output  DATAWIDTH  read data.
REQ-015 PREADY  output  1  transfer completion.
REQ-016 PSLVERR  output  1  transfer error, valid only while PREADY=1.
REQ-017 prot_err  output  1  sticky protocol-violation flag.

Function
REQ-018 SHALL run a protocol FSM with states IDLE, SETUP and ACCESS.
REQ-019 IDLE->SETUP when PSEL=1 and PENABLE=0; IDLE->IDLE when PSEL=0.
REQ-020 SETUP->ACCESS unconditionally on the next edge.
REQ-021 ACCESS->IDLE when PREADY=1 and the next sampled PSEL=0; ACCESS->SETUP when PREADY=1 and PSEL stays 1 (back-to-back transfer).
REQ-022 A 4-bit wait counter SHALL clear in IDLE and SETUP and SHALL increment each ACCESS cycle with PREADY=0.
REQ-023 PREADY SHALL equal (state==ACCESS && PSEL && PENABLE && waitcnt==WAITSTATES), decoded from registered state; WAITSTATES=0 gives completion in the first ACCESS cycle.
REQ-024 An error SHALL be flagged when word index PADDR[ADDRWIDTH-1:2] >= NUMREGS or PADDR[1:0] != 0.
REQ-025 PSLVERR SHALL be 1 only in the PREADY=1 cycle of an erroring transfer, else 0.
REQ-026 A write SHALL commit on the PREADY=1 edge when PWRITE=1 and there is no error; bytes with PSTRB[i]=1 are updated, the rest are held.
REQ-027 An erroring write SHALL leave every register unchanged.
REQ-028 PRDATA SHALL present the addressed register when PREADY=1 and PWRITE=0 with no error, and 0 at all other times.
REQ-029 PADDR, PWRITE, PWDATA and PSTRB SHALL be sampled in the completing cycle only; changes during wait states are not latched.
REQ-030 prot_err SHALL set when any of the following occurs:
- PENABLE=1 while in IDLE;
- PENABLE=1 while in SETUP;
- PSEL drops in ACCESS before PREADY=1.
REQ-031 prot_err SHALL clear only on reset.
REQ-032 On PSEL drop in ACCESS before completion, the FSM SHALL go to IDLE with no write commit.
REQ-033 A read and a write to the same register in consecutive transfers SHALL see the new value, since each transfer is at least 2 cycles.

Reset
REQ-034 While PRESET=1 at a PCLK edge, the block SHALL reset to:
- state to IDLE;
- waitcnt to 0;
- all registers to 0;
- prot_err to 0.
REQ-035 Reset SHALL hold PREADY=0, PSLVERR=0 and PRDATA=0.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer with no commit.
REQ-037 The first valid SETUP SHALL be the first cycle after PRESET deasserts.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the address-error decode function.
REQ-039 The register array with byte-strobe write SHALL be one sub-module, apb_regfile.
REQ-040 The FSM, wait counter and error logic SHALL reside in apb_reg_slave.

Verification
REQ-041 Scenario 1, WAITSTATES=1:
- stimulus: write 0xDEADBEEF to 0x08 with PSTRB=4'hF, then read 0x08;
- required response: PREADY high on the 2nd ACCESS cycle of each transfer, read PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-042 Scenario 2:
- stimulus: write 0x11223344 to 0x04, then write 0xAABBCCDD with PSTRB=4'b0101, then read 0x04;
- required response: PRDATA=0x11BB33DD.
REQ-043 Scenario 3, NUMREGS=16:
- stimulus: write to 0x40, then read 0x02;
- required response: both transfers give PSLVERR=1 with PREADY, no register changes, read PRDATA=0.
REQ-044 Scenario 4:
- stimulus: WAITSTATES=0 with back-to-back writes to 0x00 and 0x04, PSEL held high;
- required response: each transfer completes in 2 cycles and the FSM goes ACCESS->SETUP.
REQ-045 Scenario 5:
- stimulus: PENABLE=1 with PSEL=1 directly from IDLE;
- required response: prot_err=1 next cycle and it stays 1 until PRESET.
REQ-046 Scenario 6:
- stimulus: PRESET asserted during a write's wait state to 0x0C;
- required response: register 0x0C reads 0 after reset, and PREADY=0 while PRESET=1.
